addsub_pipe: RTL and testbench

//   Parametrised, pipelined add/subtract unit; successor to the fixed 32-bit combinational subtracter.

---
 rtl/addsub_pipe.sv | 120 ++++++++++++
 tb/tb_addsub_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit with a valid/ready handshake on both sides.
// The arithmetic sits in front of stage 1; later stages only delay the result.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             ovf,
  output logic             zero
);

  typedef struct packed {
    logic [WIDTH:0] res;
    logic           ovf;
    logic           zero;
  } payload_t;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_RSUB = 2'b10;
  localparam logic [1:0] MODE_ABS  = 2'b11;

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] a_minus_b;
  logic [WIDTH:0] b_minus_a;
  logic           a_lt_b;
  logic           add_ovf;
  logic           sub_ab_ovf;
  logic           sub_ba_ovf;
  payload_t       calc;

  // One extra bit on every operation: its top bit is the carry or the borrow.
  assign sum_ext   = {1'b0, a} + {1'b0, b};
  assign a_minus_b = {1'b0, a} - {1'b0, b};
  assign b_minus_a = {1'b0, b} - {1'b0, a};
  assign a_lt_b    = a_minus_b[WIDTH];

  assign add_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1]   != a[WIDTH-1]);
  assign sub_ab_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (a_minus_b[WIDTH-1] != a[WIDTH-1]);
  assign sub_ba_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (b_minus_a[WIDTH-1] != b[WIDTH-1]);

  always_comb begin
    calc.res  = '0;
    calc.ovf  = 1'b0;
    calc.zero = 1'b0;
    case (mode)
      MODE_ADD: begin
        calc.res = sum_ext;
        calc.ovf = add_ovf;
      end
      MODE_SUB: begin
        calc.res = a_minus_b;
        calc.ovf = sub_ab_ovf;
      end
      MODE_RSUB: begin
        calc.res = b_minus_a;
        calc.ovf = sub_ba_ovf;
      end
      MODE_ABS: begin
        // Top bit records that the operands were swapped to keep the value positive.
        calc.res = a_lt_b ? {1'b1, b_minus_a[WIDTH-1:0]} : {1'b0, a_minus_b[WIDTH-1:0]};
        calc.ovf = 1'b0;
      end
      default: begin
        calc.res = '0;
        calc.ovf = 1'b0;
      end
    endcase
    calc.zero = (calc.res[WIDTH-1:0] == '0);
  end

  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] stage_ready;
  logic [STAGES-1:0] up_valid;
  payload_t          pay_reg [STAGES];
  payload_t          up_pay  [STAGES];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign up_valid[gi] = in_valid;
        assign up_pay[gi]   = calc;
      end else begin : g_rest
        assign up_valid[gi] = valid_reg[gi-1];
        assign up_pay[gi]   = pay_reg[gi-1];
      end

      // A stage can load unless it and every stage after it are full and the consumer stalls.
      assign stage_ready[gi] = out_ready || !(&valid_reg[STAGES-1:gi]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
          pay_reg[gi]   <= '0;
        end else if (stage_ready[gi]) begin
          valid_reg[gi] <= up_valid[gi];
          if (up_valid[gi]) begin
            pay_reg[gi] <= up_pay[gi];
          end
        end
      end
    end
  endgenerate

  assign in_ready  = stage_ready[0];
  assign out_valid = valid_reg[STAGES-1];
  assign result    = pay_reg[STAGES-1].res;
  assign ovf       = pay_reg[STAGES-1].ovf;
  assign zero      = pay_reg[STAGES-1].zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=32, STAGES=3): directed vectors,
// stall/flow/reset scenarios and a random run against an arithmetic reference model.
module tb_addsub_pipe;
  localparam int W = 32;
  localparam int S = 3;

  typedef struct packed {
    logic [W:0] res;
    logic       ovf;
    logic       zero;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [1:0]    mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W:0]    result;
  logic          ovf;
  logic          zero;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic last_acc = 1'b0;

  addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  function automatic logic out_of_range(longint v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  // Reference: unsigned results from 64-bit arithmetic, overflow from exact signed range.
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic [1:0] m);
    exp_t   e;
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint r;
    e = '0;
    case (m)
      2'd0: begin r = ux + uy; e.res = r[W:0]; e.ovf = out_of_range(sx + sy); end
      2'd1: begin r = ux - uy; e.res = {ux < uy, r[W-1:0]}; e.ovf = out_of_range(sx - sy); end
      2'd2: begin r = uy - ux; e.res = {uy < ux, r[W-1:0]}; e.ovf = out_of_range(sy - sx); end
      default: begin
        if (ux < uy) begin r = uy - ux; e.res = {1'b1, r[W-1:0]}; end
        else         begin r = ux - uy; e.res = {1'b0, r[W-1:0]}; end
      end
    endcase
    e.zero = (e.res[W-1:0] == '0);
    return e;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock with scoreboard bookkeeping; inputs are set at the negedge before the call.
  task automatic step();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_result", 64'(result), 64'(e.res));
        check("sb_ovf", 64'(ovf), 64'(e.ovf));
        check("sb_zero", 64'(zero), 64'(e.zero));
        $display("consume result=0x%09h ovf=%0d zero=%0d", result, ovf, zero);
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      exp_q.push_back(model(a, b, mode));
      $display("accept  a=0x%08h b=0x%08h mode=%0d", a, b, mode);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single op through an empty pipe: latency plus spec-given expected values.
  task automatic single(string tag, logic [W-1:0] x, logic [W-1:0] y, logic [1:0] m,
                        logic [W:0] er, logic eo, logic ez);
    int n;
    exp_t mm;
    in_valid = 1'b1; a = x; b = y; mode = m; out_ready = 1'b1;
    mm = model(x, y, m);
    #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(S));
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    check({tag, "_zero"}, 64'(zero), 64'(ez));
    check({tag, "_model"}, 64'(mm), 64'({er, eo, ez}));
    $display("single %s a=0x%08h b=0x%08h mode=%0d result=0x%09h ovf=%0d zero=%0d",
             tag, x, y, m, result, ovf, zero);
    @(posedge clk); @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corner [5];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'h7FFFFFFF;
    corner[3] = 32'h80000000; corner[4] = 32'hFFFFFFFF;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  logic [W:0] held;

  initial begin
    // Reset state
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed vectors
    single("t1_sub",  32'h11011011, 32'h10111101, 2'b01, 33'h0_00EFFF10, 1'b0, 1'b0);
    single("t2_rsub", 32'h11011011, 32'h10111101, 2'b10, 33'h1_FF1000F0, 1'b0, 1'b0);
    single("t2_abs",  32'h11011011, 32'h10111101, 2'b11, 33'h0_00EFFF10, 1'b0, 1'b0);
    single("t2_absw", 32'h10111101, 32'h11011011, 2'b11, 33'h1_00EFFF10, 1'b0, 1'b0);
    single("t3_carry", 32'hFFFFFFFF, 32'h00000001, 2'b00, 33'h1_00000000, 1'b0, 1'b1);
    single("t3_addov", 32'h7FFFFFFF, 32'h00000001, 2'b00, 33'h0_80000000, 1'b1, 1'b0);
    single("t3_subov", 32'h80000000, 32'h00000001, 2'b01, 33'h0_7FFFFFFF, 1'b1, 1'b0);

    // Stall: fill to capacity, 4th op refused and held, then drain in order
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; a = pick(); b = pick(); mode = 2'($urandom_range(0, 3));
      #1 check("t4_in_ready", 64'(in_ready), 64'(k < S));
      step();
    end
    held = result;
    check("t4_full_out_valid", 64'(out_valid), 64'd1);
    step();
    check("t4_hold_result", 64'(result), 64'(held));
    check("t4_hold_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1 check("t4_accept_on_full", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t4_drain_valid", 64'(out_valid), 64'd1);
      step();
    end
    check("t4_empty", 64'(exp_q.size()), 64'd0);
    check("t4_idle_valid", 64'(out_valid), 64'd0);

    // Continuous flow: 10 ops, 10 back-to-back results
    out_ready = 1'b1;
    for (int j = 0; j < 10 + S; j++) begin
      in_valid = (j < 10);
      a = pick(); b = pick(); mode = 2'($urandom_range(0, 3));
      if (j < 10) begin
        #1 check("t5_in_ready", 64'(in_ready), 64'd1);
      end
      check("t5_out_valid", 64'(out_valid), 64'(j >= S));
      step();
    end
    check("t5_empty", 64'(exp_q.size()), 64'd0);

    // Random traffic with producer hold on refusal
    in_valid = 1'b0; last_acc = 1'b0;
    for (int j = 0; j < 300; j++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = pick(); b = pick(); mode = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 20 && exp_q.size() > 0; j++) step();
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two ops in flight
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; a = pick(); b = pick(); mode = 2'($urandom_range(0, 3));
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < S - 2; k++) step();
    check("t6_before_rst", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1 check("t6_async_clear", 64'(out_valid), 64'd0);
    check("t6_async_result", 64'(result), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 2 * S; k++) begin
      check("t6_no_stale", 64'(out_valid), 64'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
